// File: rtl/run_len_detector_pkg.sv
// Shared types for the run-length detector.
// FSM state and decoded input symbol encodings.
package run_len_detector_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN0 = 2'd1,
    ST_RUN1 = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SYM_IDLE = 2'd0,
    SYM_ZERO = 2'd1,
    SYM_ONE  = 2'd2,
    SYM_ILL  = 2'd3
  } sym_t;

  localparam int unsigned MIN_LEN = 2;

  function automatic sym_t sym_decode(
    input logic one,
    input logic zero
  );
    sym_t s;
    case ({one, zero})
      2'b00:   s = SYM_IDLE;
      2'b01:   s = SYM_ZERO;
      2'b10:   s = SYM_ONE;
      default: s = SYM_ILL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/run_sat_counter.sv
// Saturating run-length counter: clear, load-1, increment.
// Ports: clk, rst_n, clear, load1, inc, cnt (registered), cnt_nxt.
module run_sat_counter
  import run_len_detector_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load1,
  input  logic          inc,
  output logic [LW-1:0] cnt,
  output logic [LW-1:0] cnt_nxt
);

  localparam logic [LW-1:0] CMAX = LW'(MAX_LEN);

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      clear: cnt_nxt = '0;
      load1: cnt_nxt = LW'(1);
      inc:   cnt_nxt = (cnt == CMAX) ? cnt : cnt + LW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/run_len_detector.sv
// Detects runs of RUN_LEN identical ONE/ZERO symbols, sticky or pulse.
// Ports: CLK, RESET_N, ONE, ZERO, RUN_LEN, PULSE -> OUT, OUT_SYM, RUN_CNT, EVT_CNT, ERR.
module run_len_detector
  import run_len_detector_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 8,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ONE,
  input  logic             ZERO,
  input  logic [LW-1:0]    RUN_LEN,
  input  logic             PULSE,
  output logic             OUT,
  output logic             OUT_SYM,
  output logic [LW-1:0]    RUN_CNT,
  output logic [CNT_W-1:0] EVT_CNT,
  output logic             ERR
);

  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_MIN = LW'(MIN_LEN);

  state_t        state_q;
  state_t        state_d;
  sym_t          sym;
  logic [LW-1:0] n;
  logic [LW-1:0] cnt_nxt;
  logic [LW-1:0] cnt_p1;
  logic          clr;
  logic          ld1;
  logic          inc;
  logic          fire;
  logic          out_d;
  logic          evt_inc;

  assign sym    = sym_decode(ONE, ZERO);
  assign cnt_p1 = RUN_CNT + LW'(1);

  always_comb begin
    n = RUN_LEN;
    if (RUN_LEN < LEN_MIN) begin
      n = LEN_MIN;
    end else if (RUN_LEN > LEN_MAX) begin
      n = LEN_MAX;
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    ld1     = 1'b0;
    inc     = 1'b0;
    fire    = 1'b0;
    unique case (1'b1)
      (sym == SYM_ILL): begin
        state_d = ST_INIT;
        clr     = 1'b1;
      end
      (sym == SYM_ZERO),
      (sym == SYM_ONE): begin
        state_d = (sym == SYM_ONE) ? ST_RUN1 : ST_RUN0;
        if (state_d != state_q) begin
          ld1 = 1'b1;
        end else if (!PULSE) begin
          inc = 1'b1;
        end else if (RUN_CNT >= n) begin
          // threshold dropped below the count: this symbol starts afresh
          ld1 = 1'b1;
        end else if (cnt_p1 == n) begin
          clr  = 1'b1;
          fire = 1'b1;
        end else begin
          inc = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  assign out_d   = PULSE ? fire : (cnt_nxt >= n);
  // sticky counts rising edges; pulses never sit back to back
  assign evt_inc = out_d & (PULSE | ~OUT);

  run_sat_counter #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_cnt (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .clear   (clr),
    .load1   (ld1),
    .inc     (inc),
    .cnt     (RUN_CNT),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_INIT;
      OUT     <= 1'b0;
      ERR     <= 1'b0;
      EVT_CNT <= '0;
    end else begin
      state_q <= state_d;
      OUT     <= out_d;
      ERR     <= (sym == SYM_ILL);
      EVT_CNT <= EVT_CNT + CNT_W'(evt_inc);
    end
  end

  assign OUT_SYM = (state_q == ST_RUN1);

endmodule

// File: tb/tb_run_len_detector.sv
// Scoreboard bench for run_len_detector (MAX_LEN=8, CNT_W=2).
// Directed vectors push expectations; a monitor checks each cycle.
module tb_run_len_detector;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ONE = 1'b0;
  logic       ZERO = 1'b0;
  logic [3:0] RUN_LEN = 4'd0;
  logic       PULSE = 1'b0;
  logic       OUT;
  logic       OUT_SYM;
  logic [3:0] RUN_CNT;
  logic [1:0] EVT_CNT;
  logic       ERR;

  typedef struct {
    int         id;
    logic       out;
    logic       sym;
    logic [3:0] cnt;
    logic [1:0] evt;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  int   vec = 0;
  int   total = 0;
  int   passed = 0;

  run_len_detector #(
    .MAX_LEN (8),
    .CNT_W   (2)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .ONE     (ONE),
    .ZERO    (ZERO),
    .RUN_LEN (RUN_LEN),
    .PULSE   (PULSE),
    .OUT     (OUT),
    .OUT_SYM (OUT_SYM),
    .RUN_CNT (RUN_CNT),
    .EVT_CNT (EVT_CNT),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int id,
                     input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL vec%0d %s: got %0h want %0h", id, nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("OUT", e.id, {7'd0, OUT}, {7'd0, e.out});
      chk("OUT_SYM", e.id, {7'd0, OUT_SYM}, {7'd0, e.sym});
      chk("RUN_CNT", e.id, {4'd0, RUN_CNT}, {4'd0, e.cnt});
      chk("EVT_CNT", e.id, {6'd0, EVT_CNT}, {6'd0, e.evt});
      chk("ERR", e.id, {7'd0, ERR}, {7'd0, e.err});
    end
  end

  task automatic step(input logic rn, input logic o, input logic z,
                      input logic [3:0] rl, input logic pl,
                      input logic eo, input logic es,
                      input logic [3:0] ec, input logic [1:0] ee,
                      input logic er);
    exp_t e;
    RESET_N = rn;
    ONE     = o;
    ZERO    = z;
    RUN_LEN = rl;
    PULSE   = pl;
    @(posedge CLK);
    e.id  = vec;
    e.out = eo;
    e.sym = es;
    e.cnt = ec;
    e.evt = ee;
    e.err = er;
    sbq.push_back(e);
    vec++;
    #1;
  endtask

  initial begin
    logic [1:0] ev;
    #1;
    // reset with ONE high
    step(0, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    // sticky N=4 on ZERO
    step(1, 0, 1, 4, 0, 0, 0, 1, 0, 0);
    step(1, 0, 1, 4, 0, 0, 0, 2, 0, 0);
    step(1, 0, 1, 4, 0, 0, 0, 3, 0, 0);
    step(1, 0, 1, 4, 0, 1, 0, 4, 1, 0);
    step(1, 0, 0, 4, 0, 1, 0, 4, 1, 0);
    step(1, 0, 0, 4, 0, 1, 0, 4, 1, 0);
    step(1, 1, 0, 4, 0, 0, 1, 1, 1, 0);
    // pulse N=3: fresh ONE run of 7
    step(1, 0, 1, 3, 1, 0, 0, 1, 1, 0);
    step(1, 1, 0, 3, 1, 0, 1, 1, 1, 0);
    step(1, 1, 0, 3, 1, 0, 1, 2, 1, 0);
    step(1, 1, 0, 3, 1, 1, 1, 0, 2, 0);
    step(1, 1, 0, 3, 1, 0, 1, 1, 2, 0);
    step(1, 1, 0, 3, 1, 0, 1, 2, 2, 0);
    step(1, 1, 0, 3, 1, 1, 1, 0, 3, 0);
    step(1, 1, 0, 3, 1, 0, 1, 1, 3, 0);
    // illegal input mid-run
    step(1, 0, 1, 4, 0, 0, 0, 1, 3, 0);
    step(1, 0, 1, 4, 0, 0, 0, 2, 3, 0);
    step(1, 0, 1, 4, 0, 0, 0, 3, 3, 0);
    step(1, 1, 1, 4, 0, 0, 0, 0, 3, 1);
    step(1, 0, 1, 4, 0, 0, 0, 1, 3, 0);
    // clamp low: RUN_LEN=0 -> N=2
    step(1, 1, 0, 0, 0, 0, 1, 1, 3, 0);
    step(1, 1, 0, 0, 0, 1, 1, 2, 0, 0);
    // clamp high: RUN_LEN=15 -> N=8
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 1, 15, 0, (k == 8), 0, 4'(k), (k == 8) ? 2'd1 : 2'd0, 0);
    end
    // saturation at 8 over 12 ONEs
    for (int k = 1; k <= 12; k++) begin
      step(1, 1, 0, 15, 0, (k >= 8), 1, (k >= 8) ? 4'd8 : 4'(k),
           (k >= 8) ? 2'd2 : 2'd1, 0);
    end
    // sticky threshold changed during idle
    step(1, 0, 1, 2, 0, 0, 0, 1, 2, 0);
    step(1, 0, 1, 2, 0, 1, 0, 2, 3, 0);
    step(1, 0, 0, 4, 0, 0, 0, 2, 3, 0);
    step(1, 0, 0, 2, 0, 1, 0, 2, 0, 0);
    // into pulse with count already at N: restart
    step(1, 0, 1, 2, 1, 0, 0, 1, 0, 0);
    step(1, 0, 1, 2, 1, 1, 0, 0, 1, 0);
    // five pulses at N=2, counter wraps
    ev = 2'd1;
    for (int p = 0; p < 5; p++) begin
      step(1, 1, 0, 2, 1, 0, 1, 1, ev, 0);
      ev = ev + 2'd1;
      step(1, 1, 0, 2, 1, 1, 1, 0, ev, 0);
    end
    step(1, 0, 0, 2, 1, 0, 1, 0, 2, 0);
    step(1, 1, 0, 2, 1, 0, 1, 1, 2, 0);
    // mid-run reset
    step(0, 1, 0, 2, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 2, 1, 0, 1, 1, 0, 0);
    RESET_N = 1'b1;
    ONE     = 1'b0;
    ZERO    = 1'b0;
    repeat (4) @(negedge CLK);
    total++;
    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end else begin
      passed++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
